// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [SEL_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | SEL_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/eight_to_one_mux.sv
// Single-bit 8:1 multiplexer cell.
// Latency: combinational.
// Backpressure: none.
module eight_to_one_mux (
    input  logic i7,
    input  logic i6,
    input  logic i5,
    input  logic i4,
    input  logic i3,
    input  logic i2,
    input  logic i1,
    input  logic i0,
    input  logic s2,
    input  logic s1,
    input  logic s0,
    output logic d
);

    logic [7:0] i_vec;

    assign i_vec = {i7, i6, i5, i4, i3, i2, i1, i0};
    assign d     = i_vec[{s2, s1, s0}];

endmodule

// File: rtl/rr_priority_picker.sv
// Finds the first unmasked request at or after start, wrapping 7 -> 0.
// Latency: combinational.
// Backpressure: none.
module rr_priority_picker
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] start,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // 3-bit addition wraps naturally, giving the circular search order.
            cand = start + SEL_W'(i);
            if (!found && req[cand] && !mask[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 8:1 bit mux with bounded tenure per requester.
// Latency: req -> gnt/sel/busy 1 cycle; data_in -> data_out combinational.
// Backpressure: none; losers keep req high until granted.
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 4,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] data_in,
    output logic [N_REQ-1:0] gnt,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             data_out
);

    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] gnt_d;
    logic [SEL_W-1:0] sel_d;
    logic             busy_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    logic [SEL_W-1:0] pick_start;
    logic [N_REQ-1:0] pick_mask;
    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic [N_REQ-1:0] pick_gnt;
    logic             mux_d;

    // While owning, search starts after the owner with the owner masked out,
    // so release and expiry share the single picker.
    assign pick_start = (state_q == GRANT) ? sel + SEL_W'(1) : ptr_q;
    assign pick_mask  = (state_q == GRANT) ? gnt : '0;
    assign pick_gnt   = N_REQ'(1) << pick_idx;

    rr_priority_picker u_picker (
        .req   (req),
        .start (pick_start),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt;
        sel_d   = sel;
        busy_d  = busy;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANT;
                    gnt_d   = pick_gnt;
                    sel_d   = onehot_to_idx(pick_gnt);
                    busy_d  = 1'b1;
                    hold_d  = HOLD_ONE;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    ptr_d = sel + SEL_W'(1);
                    if (pick_found) begin
                        gnt_d  = pick_gnt;
                        sel_d  = onehot_to_idx(pick_gnt);
                        hold_d = HOLD_ONE;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_MAX) begin
                    // With no other contender the owner simply restarts its tenure.
                    hold_d = HOLD_ONE;
                    if (pick_found) begin
                        ptr_d = sel + SEL_W'(1);
                        gnt_d = pick_gnt;
                        sel_d = onehot_to_idx(pick_gnt);
                    end
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
            sel     <= sel_d;
            busy    <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    eight_to_one_mux u_mux (
        .i7 (data_in[7]),
        .i6 (data_in[6]),
        .i5 (data_in[5]),
        .i4 (data_in[4]),
        .i3 (data_in[3]),
        .i2 (data_in[2]),
        .i1 (data_in[1]),
        .i0 (data_in[0]),
        .s2 (sel[2]),
        .s1 (sel[1]),
        .s0 (sel[0]),
        .d  (mux_d)
    );

    assign data_out = mux_d & busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scenario tasks plus randomized traffic against a behavioural arbiter model.
module tb_mux_rr_arbiter;

    localparam int M = 4;

    logic       clk;
    logic       reset;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       data_out;

    int n_checks;
    int n_pass;

    // Behavioural model: who owns, for how long, and where the search starts.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_hold;

    mux_rr_arbiter #(.MAX_HOLD(M), .HOLD_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .data_in  (data_in),
        .gnt      (gnt),
        .sel      (sel),
        .busy     (busy),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int find_next(input logic [7:0] q, input int start, input int excl);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (start + k) % 8;
            if (idx != excl && q[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_gnt();
        return m_busy ? (8'd1 << m_owner) : 8'd0;
    endfunction

    function automatic logic exp_dout();
        return m_busy ? data_in[m_owner] : 1'b0;
    endfunction

    task automatic model_update();
        int n;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_busy) begin
            n = find_next(req, m_ptr, -1);
            if (n >= 0) begin
                m_busy = 1; m_owner = n; m_hold = 1;
            end
        end else if (!req[m_owner]) begin
            n = find_next(req, (m_owner + 1) % 8, m_owner);
            m_ptr = (m_owner + 1) % 8;
            if (n >= 0) begin
                m_owner = n; m_hold = 1;
            end else begin
                m_busy = 0; m_hold = 0;
            end
        end else if (m_hold == M) begin
            n = find_next(req, (m_owner + 1) % 8, m_owner);
            if (n >= 0) begin
                m_ptr = (m_owner + 1) % 8; m_owner = n;
            end
            m_hold = 1;
        end else begin
            m_hold++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 8'hFF;
        data_in = 8'hFF;
        step();
        step();
        n_checks++; if (gnt !== 8'h00) $display("FAIL reset_gnt got %h want 00", gnt); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_checks++; if (sel !== 3'd0) $display("FAIL reset_sel got %0d want 0", sel); else n_pass++;
        n_checks++; if (data_out !== 1'b0) $display("FAIL reset_dout got %b want 0", data_out); else n_pass++;
        reset = 1'b0;
        step();
        n_checks++; if (gnt !== 8'h01) $display("FAIL reset_first_gnt got %h want 01", gnt); else n_pass++;
        n_checks++; if (gnt !== exp_gnt()) $display("FAIL reset_first_model got %h want %h", gnt, exp_gnt()); else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        req = 8'h10;
        for (int c = 0; c < 10; c++) begin
            step();
            n_checks++; if (gnt !== 8'h10 || sel !== 3'd4) $display("FAIL single_hold cyc %0d got gnt %h sel %0d want 10/4", c, gnt, sel); else n_pass++;
        end
        req = 8'h00;
        step();
        n_checks++; if (busy !== 1'b0 || gnt !== 8'h00) $display("FAIL single_release got busy %b gnt %h want 0/00", busy, gnt); else n_pass++;
    endtask

    task automatic test_contention();
        logic [7:0] want;
        apply_reset();
        req = 8'h05;
        for (int c = 1; c <= 12; c++) begin
            step();
            want = (((c - 1) / 4) % 2 == 0) ? 8'h01 : 8'h04;
            n_checks++; if (gnt !== want) $display("FAIL contention cyc %0d got %h want %h", c, gnt, want); else n_pass++;
        end
        n_checks++; if (busy !== 1'b1) $display("FAIL contention_busy got %b want 1", busy); else n_pass++;
    endtask

    task automatic test_wrap();
        apply_reset();
        req = 8'h80;
        step();
        n_checks++; if (gnt !== 8'h80 || sel !== 3'd7) $display("FAIL wrap_first got %h/%0d want 80/7", gnt, sel); else n_pass++;
        req = 8'h81;
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++; if (gnt !== 8'h80) $display("FAIL wrap_hold cyc %0d got %h want 80", c, gnt); else n_pass++;
        end
        step();
        n_checks++; if (gnt !== 8'h01 || sel !== 3'd0) $display("FAIL wrap_expiry got %h/%0d want 01/0", gnt, sel); else n_pass++;
        for (int c = 0; c < 4; c++) step();
        n_checks++; if (gnt !== 8'h80 || gnt !== exp_gnt()) $display("FAIL wrap_back got %h want 80", gnt); else n_pass++;
    endtask

    task automatic test_early_release();
        apply_reset();
        req = 8'h0A;
        data_in = 8'h08;
        step();
        n_checks++; if (gnt !== 8'h02 || data_out !== 1'b0) $display("FAIL early_owner1 got %h/%b want 02/0", gnt, data_out); else n_pass++;
        step();
        n_checks++; if (data_out !== 1'b0) $display("FAIL early_dout1 got %b want 0", data_out); else n_pass++;
        req = 8'h08;
        step();
        n_checks++; if (gnt !== 8'h08 || sel !== 3'd3) $display("FAIL early_handover got %h/%0d want 08/3", gnt, sel); else n_pass++;
        n_checks++; if (data_out !== 1'b1) $display("FAIL early_dout3 got %b want 1", data_out); else n_pass++;
        data_in = 8'hF7;
        #1;
        n_checks++; if (data_out !== 1'b0) $display("FAIL early_dout_comb got %b want 0", data_out); else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 8'h20;
        data_in = 8'h20;
        step(); step(); step();
        n_checks++; if (gnt !== 8'h20 || m_hold != 3) $display("FAIL mid_setup got %h want 20", gnt); else n_pass++;
        reset = 1'b1;
        step();
        n_checks++; if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0 || data_out !== 1'b0)
            $display("FAIL mid_reset got gnt %h sel %0d busy %b dout %b want 00/0/0/0", gnt, sel, busy, data_out);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++; if (gnt !== 8'h20 || sel !== 3'd5 || data_out !== 1'b1) $display("FAIL mid_regrant got %h/%0d/%b want 20/5/1", gnt, sel, data_out); else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        req = 8'h00;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            data_in = 8'($urandom);
            reset = ($urandom_range(0, 39) == 0);
            step();
            n_checks++;
            if (gnt !== exp_gnt() || sel !== 3'(m_owner) || busy !== m_busy || data_out !== exp_dout())
                $display("FAIL random cyc %0d got gnt %h sel %0d busy %b dout %b want %h/%0d/%b/%b",
                         c, gnt, sel, busy, data_out, exp_gnt(), m_owner, m_busy, exp_dout());
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0;
        reset   = 1'b1;
        req     = 8'h00;
        data_in = 8'h00;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_early_release();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
